fetch_ctrl: RTL and testbench

Sequencer that owns the program counter and drives the fetch stage's `pc` / `enabled` inputs. It arbitrates among four sources of the next PC: sequential advance, branch/jump redirect, trap entry, and trap return (`mret`). It also inserts a configurable number of flush bubbles after any control-flow change. It sits between the hazard/execute/CSR logic and the fetch stage.

---
 rtl/fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_ctrl_pc_select.sv | 52 +++++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencer: controller states, next-PC sources
// and the machine word width.
package fetch_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_RUN,
    FC_FLUSH,
    FC_HALT
  } fc_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_BR,
    SRC_TRAP,
    SRC_MRET
  } pc_src_t;

  // Sources that change control flow and therefore require flush bubbles.
  function automatic logic is_redirect(input pc_src_t src);
    return (src == SRC_BR) || (src == SRC_TRAP) || (src == SRC_MRET);
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_select.sv
// Combinational next-PC priority mux:
// trap > mret > redirect > halt/stall (hold) > sequential.
module pc_select
  import fetch_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] next_pc,
  output pc_src_t         src,
  output logic            out_of_range
);

  localparam logic [XLEN:0] DEPTH_EXT = (XLEN + 1)'(IMEM_DEPTH);

  // Widened compare so a depth of 2^32 would still be representable.
  function automatic logic beyond_imem(input logic [XLEN-1:0] addr);
    return {1'b0, addr} >= DEPTH_EXT;
  endfunction

  always_comb begin
    next_pc = pc;
    src     = SRC_SEQ;
    if (trap_valid) begin
      next_pc = mtvec;
      src     = SRC_TRAP;
    end else if (mret_valid) begin
      next_pc = mepc;
      src     = SRC_MRET;
    end else if (redirect_valid) begin
      next_pc = redirect_pc;
      src     = SRC_BR;
    end else if (halt_req || stall) begin
      next_pc = pc;
      src     = SRC_HOLD;
    end else begin
      next_pc = pc + 1'b1;
      src     = SRC_SEQ;
    end
  end

  assign out_of_range = beyond_imem(next_pc);

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: owns the PC, arbitrates redirect/trap/mret,
// inserts flush bubbles after control-flow changes and halts on request.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int RESET_PC   = 0,
  parameter int IMEM_DEPTH = 64,
  parameter int BUBBLES    = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic            fetch_en,
  output logic            flush,
  output logic            halted,
  output logic            range_err
);

  localparam logic [3:0]      CNT_LOAD = 4'(BUBBLES - 1);
  localparam logic [XLEN-1:0] PC_RST   = XLEN'(RESET_PC);

  fc_state_t       state;
  logic [3:0]      bubble_cnt;
  logic [XLEN-1:0] next_pc;
  pc_src_t         src;
  logic            out_of_range;

  pc_select #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_pc_select (
    .pc             (pc),
    .stall          (stall),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .mtvec          (mtvec),
    .mret_valid     (mret_valid),
    .mepc           (mepc),
    .next_pc        (next_pc),
    .src            (src),
    .out_of_range   (out_of_range)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= FC_IDLE;
      pc         <= PC_RST;
      bubble_cnt <= '0;
      range_err  <= 1'b0;
    end else begin
      case (state)
        FC_IDLE: state <= FC_RUN;
        FC_RUN: begin
          if (src != SRC_HOLD && out_of_range) begin
            state     <= FC_HALT;
            range_err <= 1'b1;
          end else if (is_redirect(src)) begin
            pc         <= next_pc;
            bubble_cnt <= CNT_LOAD;
            state      <= FC_FLUSH;
          end else if (halt_req) begin
            state <= FC_HALT;
          end else if (src == SRC_SEQ) begin
            pc <= next_pc;
          end
        end
        // Stall and halt_req are ignored here; only control-flow events restart the bubbles.
        FC_FLUSH: begin
          if (is_redirect(src)) begin
            if (out_of_range) begin
              state     <= FC_HALT;
              range_err <= 1'b1;
            end else begin
              pc         <= next_pc;
              bubble_cnt <= CNT_LOAD;
            end
          end else if (bubble_cnt == 4'd0) begin
            state <= FC_RUN;
          end else begin
            bubble_cnt <= bubble_cnt - 4'd1;
          end
        end
        FC_HALT: state <= FC_HALT;
        default: state <= FC_IDLE;
      endcase
    end
  end

  assign fetch_en = (state == FC_RUN) && !stall;
  assign flush    = (state == FC_FLUSH);
  assign halted   = (state == FC_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] mtvec;
  logic        mret_valid;
  logic [31:0] mepc;
  logic        halt_req;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic        halted;
  logic        range_err;

  typedef struct {
    logic [31:0] pc;
    logic        fe;
    logic        fl;
    logic        h;
    logic        re;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_ctrl #(
    .RESET_PC   (0),
    .IMEM_DEPTH (64),
    .BUBBLES    (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .mtvec          (mtvec),
    .mret_valid     (mret_valid),
    .mepc           (mepc),
    .halt_req       (halt_req),
    .pc             (pc),
    .fetch_en       (fetch_en),
    .flush          (flush),
    .halted         (halted),
    .range_err      (range_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares the state presented while the current inputs are applied.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_en !== e.fe || flush !== e.fl ||
          halted !== e.h || range_err !== e.re) begin
        n_fail++;
        $display("FAIL %s: got pc=%0d fe=%b fl=%b h=%b re=%b, want pc=%0d fe=%b fl=%b h=%b re=%b",
                 e.name, pc, fetch_en, flush, halted, range_err,
                 e.pc, e.fe, e.fl, e.h, e.re);
      end
    end
  end

  task automatic expect_out(input logic [31:0] p, input logic fe, input logic fl,
                            input logic h, input logic re, input string name);
    exp_t e;
    e.pc = p; e.fe = fe; e.fl = fl; e.h = h; e.re = re; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    mret_valid = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; redirect_pc = '0; mtvec = '0; mepc = '0;
    clr();
    tick();
    tick();
    expect_out(0, 0, 0, 0, 0, "reset");
    tick();
    rstn = 1'b1;
    expect_out(0, 0, 0, 0, 0, "idle_cycle0");
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'd20;
      end
      expect_out(i, 1, 0, 0, 0, $sformatf("seq_%0d", i));
      tick();
    end
    clr();
    expect_out(20, 0, 1, 0, 0, "br_bubble0"); tick();
    expect_out(20, 0, 1, 0, 0, "br_bubble1"); tick();
    expect_out(20, 1, 0, 0, 0, "br_run20");   tick();
    expect_out(21, 1, 0, 0, 0, "br_run21");   tick();
    // trap beats redirect and stall in the same cycle
    trap_valid = 1'b1; mtvec = 32'd47;
    redirect_valid = 1'b1; redirect_pc = 32'd3; stall = 1'b1;
    expect_out(22, 0, 0, 0, 0, "trap_issue"); tick();
    clr();
    expect_out(47, 0, 1, 0, 0, "trap_bubble0"); tick();
    expect_out(47, 0, 1, 0, 0, "trap_bubble1"); tick();
    expect_out(47, 1, 0, 0, 0, "trap_run47");   tick();
    mret_valid = 1'b1; mepc = 32'd9;
    expect_out(48, 1, 0, 0, 0, "mret_issue"); tick();
    clr();
    expect_out(9, 0, 1, 0, 0, "mret_bubble0"); tick();
    expect_out(9, 0, 1, 0, 0, "mret_bubble1"); tick();
    expect_out(9, 1, 0, 0, 0, "mret_run9");     tick();
    expect_out(10, 1, 0, 0, 0, "run10");        tick();
    expect_out(11, 1, 0, 0, 0, "run11");        tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out(12, 0, 0, 0, 0, $sformatf("stall_%0d", i));
      tick();
    end
    stall = 1'b0;
    expect_out(12, 1, 0, 0, 0, "stall_drop"); tick();
    redirect_valid = 1'b1; redirect_pc = 32'd30;
    expect_out(13, 1, 0, 0, 0, "after_stall13"); tick();
    clr();
    // trap during FLUSH replaces pc and restarts the bubbles; stall is ignored
    trap_valid = 1'b1; mtvec = 32'd40; stall = 1'b1;
    expect_out(30, 0, 1, 0, 0, "flush_trap_in"); tick();
    clr();
    expect_out(40, 0, 1, 0, 0, "reflush0"); tick();
    expect_out(40, 0, 1, 0, 0, "reflush1"); tick();
    expect_out(40, 1, 0, 0, 0, "reflush_run40"); tick();
    redirect_valid = 1'b1; redirect_pc = 32'd64;
    expect_out(41, 1, 0, 0, 0, "range_issue"); tick();
    clr();
    redirect_valid = 1'b1; redirect_pc = 32'd5; trap_valid = 1'b1; mtvec = 32'd2;
    expect_out(41, 0, 0, 1, 1, "range_halt"); tick();
    clr();
    expect_out(41, 0, 0, 1, 1, "halt_ignores_redirect"); tick();
    rstn = 1'b0;
    expect_out(41, 0, 0, 1, 1, "halt_before_reset"); tick();
    rstn = 1'b1;
    expect_out(0, 0, 0, 0, 0, "halt_reset_idle"); tick();
    expect_out(0, 1, 0, 0, 0, "rerun0"); tick();
    redirect_valid = 1'b1; redirect_pc = 32'd50;
    expect_out(1, 1, 0, 0, 0, "rerun1"); tick();
    clr();
    rstn = 1'b0;
    expect_out(50, 0, 1, 0, 0, "flush_before_reset"); tick();
    expect_out(0, 0, 0, 0, 0, "flush_reset"); tick();
    rstn = 1'b1;
    expect_out(0, 0, 0, 0, 0, "flush_reset_idle"); tick();
    halt_req = 1'b1;
    expect_out(0, 1, 0, 0, 0, "halt_req_issue"); tick();
    clr();
    expect_out(0, 0, 0, 1, 0, "halt_req_halted"); tick();
    expect_out(0, 0, 0, 1, 0, "halt_req_stays"); tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
